// File: rtl/battleship_pkg.sv
// Shared constants and types for the battleship game datapath.
package battleship_pkg;

  localparam int unsigned BOARD_N = 5;
  localparam int unsigned CELLS   = BOARD_N * BOARD_N;
  localparam int unsigned ADDR_W  = $clog2(CELLS);
  localparam int unsigned CNT_W   = 5;

  typedef logic [ADDR_W-1:0] cell_addr_t;
  typedef logic [CNT_W-1:0]  cell_cnt_t;
  typedef logic [ADDR_W:0]   atk_cnt_t;

  localparam cell_addr_t LAST_CELL = cell_addr_t'(CELLS - 1);
  localparam atk_cnt_t   ATK_FULL  = atk_cnt_t'(CELLS);

  typedef enum logic [2:0] {
    StIdle,
    StPick,
    StProbe,
    StRead,
    StApply,
    StDone,
    StWait
  } pc_attack_state_t;

  // Fold a raw LFSR slice into the 0..CELLS-1 range.
  function automatic cell_addr_t wrap_candidate(cell_addr_t raw);
    return (raw >= cell_addr_t'(CELLS)) ? raw - cell_addr_t'(CELLS) : raw;
  endfunction

  function automatic cell_addr_t next_cell(cell_addr_t a);
    return (a == LAST_CELL) ? '0 : a + cell_addr_t'(1);
  endfunction

endpackage

// File: rtl/pc_attack_engine_if.sv
// Controller/memory/marker signals of the PC attack engine.
interface pc_attack_engine_if;
  import battleship_pkg::*;

  logic       pc_turn;
  logic       load_cells;
  cell_cnt_t  ship_cell_count;
  cell_addr_t cell_rd_addr;
  logic       cell_rd_en;
  logic       cell_ship;
  logic       mark_we;
  cell_addr_t mark_addr;
  logic       mark_hit;
  logic       pc_move;
  cell_cnt_t  cells_left;
  logic       player_ships_zero;

  modport master (
    output pc_turn, load_cells, ship_cell_count, cell_ship,
    input  cell_rd_addr, cell_rd_en, mark_we, mark_addr, mark_hit, pc_move,
           cells_left, player_ships_zero
  );

  modport slave (
    input  pc_turn, load_cells, ship_cell_count, cell_ship,
    output cell_rd_addr, cell_rd_en, mark_we, mark_addr, mark_hit, pc_move,
           cells_left, player_ships_zero
  );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic fb;
  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {q[6:0], fb};
  end

endmodule

// File: rtl/pc_attack_engine.sv
// PC move executor: picks an unattacked player cell, reads it, marks hit/miss
// and tracks remaining player ship cells.
module pc_attack_engine
  import battleship_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  pc_attack_engine_if.slave bus
);

  pc_attack_state_t state_q, state_d;
  logic             pc_turn_q;
  cell_addr_t       addr_q, addr_d;
  logic [CELLS-1:0] mask_q, mask_d;
  atk_cnt_t         atk_q, atk_d;
  cell_cnt_t        left_q, left_d;
  logic             rd_en_q, rd_en_d;
  cell_addr_t       rd_addr_q, rd_addr_d;
  logic             mark_we_q, mark_we_d;
  cell_addr_t       mark_addr_q, mark_addr_d;
  logic             mark_hit_q, mark_hit_d;
  logic             pc_move_q, pc_move_d;
  logic             zero_q, zero_d;
  logic [7:0]       lfsr_q;
  logic             unused_lfsr;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[7:ADDR_W];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    atk_d       = atk_q;
    left_d      = left_q;
    rd_addr_d   = rd_addr_q;
    mark_we_d   = 1'b0;
    mark_addr_d = mark_addr_q;
    mark_hit_d  = mark_hit_q;

    unique case (state_q)
      StIdle: begin
        if (bus.load_cells) begin
          left_d = bus.ship_cell_count;
          mask_d = '0;
          atk_d  = '0;
        end
        if (bus.pc_turn && !pc_turn_q) state_d = StPick;
      end
      StPick: begin
        if (atk_q == ATK_FULL) begin
          state_d = StDone;
        end else begin
          addr_d  = wrap_candidate(lfsr_q[ADDR_W-1:0]);
          state_d = StProbe;
        end
      end
      StProbe: begin
        // Linear probe past already-attacked cells; a free one always exists.
        if (mask_q[addr_q]) begin
          addr_d = next_cell(addr_q);
        end else begin
          rd_addr_d = addr_q;
          state_d   = StRead;
        end
      end
      StRead: state_d = StApply;
      StApply: begin
        mark_we_d      = 1'b1;
        mark_addr_d    = addr_q;
        mark_hit_d     = bus.cell_ship;
        mask_d[addr_q] = 1'b1;
        atk_d          = atk_q + atk_cnt_t'(1);
        if (bus.cell_ship && (left_q != '0)) left_d = left_q - cell_cnt_t'(1);
        state_d = StDone;
      end
      StDone: state_d = StWait;
      // Hold off until the controller leaves PC turn so a late exit cannot retrigger.
      StWait: if (!bus.pc_turn) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    rd_en_d   = (state_d == StRead);
    pc_move_d = (state_d == StDone);
    zero_d    = (left_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_turn_q   <= 1'b0;
      addr_q      <= '0;
      mask_q      <= '0;
      atk_q       <= '0;
      left_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      mark_we_q   <= 1'b0;
      mark_addr_q <= '0;
      mark_hit_q  <= 1'b0;
      pc_move_q   <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_turn_q   <= bus.pc_turn;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      atk_q       <= atk_d;
      left_q      <= left_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      mark_we_q   <= mark_we_d;
      mark_addr_q <= mark_addr_d;
      mark_hit_q  <= mark_hit_d;
      pc_move_q   <= pc_move_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.cell_rd_en        = rd_en_q;
  assign bus.cell_rd_addr      = rd_addr_q;
  assign bus.mark_we           = mark_we_q;
  assign bus.mark_addr         = mark_addr_q;
  assign bus.mark_hit          = mark_hit_q;
  assign bus.pc_move           = pc_move_q;
  assign bus.cells_left        = left_q;
  assign bus.player_ships_zero = zero_q;

endmodule

// File: tb/tb_pc_attack_engine.sv
// Directed bench for pc_attack_engine with a one-cycle-latency board memory model.
module tb_pc_attack_engine;
  import battleship_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_val;
  always #5 clk = ~clk;

  pc_attack_engine_if bus ();

  pc_attack_engine #(
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Board memory: every cell reads as mem_val, one cycle after the strobe.
  always @(posedge clk or posedge rst) begin
    if (rst)                 bus.cell_ship <= 1'b0;
    else if (bus.cell_rd_en) bus.cell_ship <= mem_val;
  end

  int n_checks = 0;
  int n_errors = 0;
  int t_lat, t_marks, t_rds, t_moves, t_addr, t_hit;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pc_turn = 1'b0;
    bus.load_cells = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    bus.ship_cell_count = cell_cnt_t'(n);
    bus.load_cells = 1'b1;
    @(posedge clk);
    #1;
    bus.load_cells = 1'b0;
  endtask

  // One PC turn over a fixed 70-cycle window; called #1 after a rising edge.
  task automatic run_turn(input int hold_after, input bit drop_on_rd,
                          input int load_at, input int load_val);
    t_lat = 0; t_marks = 0; t_rds = 0; t_moves = 0; t_addr = 99; t_hit = 0;
    bus.pc_turn = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      bus.load_cells = (c == load_at);
      if (c == load_at) bus.ship_cell_count = cell_cnt_t'(load_val);
      if (bus.mark_we) begin
        t_marks++;
        t_addr = int'(bus.mark_addr);
        t_hit  = int'(bus.mark_hit);
      end
      if (bus.cell_rd_en) begin
        t_rds++;
        if (drop_on_rd) bus.pc_turn = 1'b0;
      end
      if (bus.pc_move) begin
        t_moves++;
        if (t_moves == 1) t_lat = c;
      end
      if (t_moves > 0 && c >= t_lat + hold_after) bus.pc_turn = 1'b0;
    end
  endtask

  logic [31:0] seen;
  int missing;

  initial begin
    rst = 1'b1;
    bus.pc_turn = 1'b0;
    bus.load_cells = 1'b0;
    bus.ship_cell_count = '0;
    mem_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cells_left", bus.cells_left, 0);
    check_eq("rst_zero", bus.player_ships_zero, 1);
    check_eq("rst_pc_move", bus.pc_move, 0);
    check_eq("rst_mark_we", bus.mark_we, 0);
    check_eq("rst_rd_en", bus.cell_rd_en, 0);
    check_eq("rst_mark_addr", bus.mark_addr, 0);
    check_eq("rst_lfsr", dut.u_lfsr.q, 8'hA5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_lfsr", dut.u_lfsr.q, 8'hA5);
    @(posedge clk);
    #1;

    // Basic hit, then handshake variants on the same board.
    load(3);
    mem_val = 1'b1;
    check_eq("load_zero", bus.player_ships_zero, 0);
    run_turn(0, 1'b0, 0, 0);
    check_eq("hit_marks", t_marks, 1);
    check_eq("hit_flag", t_hit, 1);
    check_eq("hit_rds", t_rds, 1);
    check_eq("hit_moves", t_moves, 1);
    check_eq("hit_latency", t_lat, 5);
    check_eq("hit_left", bus.cells_left, 2);

    run_turn(20, 1'b0, 0, 0);
    check_eq("hold_moves", t_moves, 1);
    check_eq("hold_left", bus.cells_left, 1);

    run_turn(0, 1'b1, 0, 0);
    check_eq("drop_moves", t_moves, 1);
    check_eq("drop_marks", t_marks, 1);
    check_eq("drop_left", bus.cells_left, 0);
    check_eq("drop_zero", bus.player_ships_zero, 1);

    run_turn(0, 1'b0, 0, 0);
    check_eq("sat_hit", t_hit, 1);
    check_eq("sat_left", bus.cells_left, 0);
    check_eq("sat_zero", bus.player_ships_zero, 1);

    // load_cells while probing must be ignored.
    do_reset();
    load(4);
    run_turn(0, 1'b0, 2, 20);
    check_eq("probe_load_moves", t_moves, 1);
    check_eq("probe_load_left", bus.cells_left, 3);

    // Defeat path from a single ship cell.
    do_reset();
    load(1);
    check_eq("defeat_pre_zero", bus.player_ships_zero, 0);
    run_turn(0, 1'b0, 0, 0);
    check_eq("defeat_left", bus.cells_left, 0);
    check_eq("defeat_zero", bus.player_ships_zero, 1);

    // Whole-board coverage with misses; the last turn is forced onto the only free cell.
    do_reset();
    load(0);
    mem_val = 1'b0;
    seen = '0;
    for (int t = 0; t < 25; t++) begin
      missing = 99;
      for (int i = 0; i < 25; i++) if (!seen[i]) missing = i;
      run_turn(0, 1'b0, 0, 0);
      check_eq("cov_marks", t_marks, 1);
      check_eq("cov_miss", t_hit, 0);
      check_eq("cov_new", (t_addr < 25) && !seen[t_addr[4:0]], 1);
      if (t == 24) check_eq("cov_last_addr", t_addr, missing);
      if (t_addr < 25) seen[t_addr[4:0]] = 1'b1;
    end
    check_eq("cov_all", seen, 32'h01FF_FFFF);
    run_turn(0, 1'b0, 0, 0);
    check_eq("full_moves", t_moves, 1);
    check_eq("full_marks", t_marks, 0);
    check_eq("full_rds", t_rds, 0);

    // Asynchronous reset in the middle of a read.
    do_reset();
    load(3);
    mem_val = 1'b1;
    bus.pc_turn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_pre_rd", bus.cell_rd_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rd_en", bus.cell_rd_en, 0);
    check_eq("mid_pc_move", bus.pc_move, 0);
    check_eq("mid_left", bus.cells_left, 0);
    check_eq("mid_zero", bus.player_ships_zero, 1);
    check_eq("mid_mark_we", bus.mark_we, 0);
    bus.pc_turn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_lfsr", dut.u_lfsr.q, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
